shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
Sequencer for a serial shift chain. It accepts a parallel word over a valid/ready handshake and drives the chain with shift_en and ser_out for exactly WIDTH cycles. In the same cycles it samples the chain tail (ser_in) and assembles a returned parallel word. It sits between a register-level requester and the serial shift datapath, and inserts a configurable idle gap between frames.

Parameters:
WIDTH, 10, bits per frame (matches chain depth); legal range 2..32
GAP, 2, idle cycles forced after each completed or aborted frame; 0 is legal
LSB_FIRST, 0, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
load_valid  in  1  requester presents load_data
load_data  in  WIDTH  parallel word to shift out
load_ready  out  1  controller can accept a word
abort  in  1  terminate the current frame
ser_in  in  1  serial bit from the chain tail, sampled while shift_en=1
shift_en  out  1  chain shift enable
ser_out  out  1  serial bit into the chain head
busy  out  1  state is not IDLE
cap_valid  out  1  one-cycle pulse: cap_data updated
cap_data  out  WIDTH  word assembled from ser_in
aborted  out  1  one-cycle pulse: frame was aborted

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst is synchronous, active-high.
  - In a reset cycle: state=IDLE, shift_en=0, ser_out=0, busy=0, cap_valid=0, aborted=0, cap_data=0, internal counters=0.
  - A load presented during rst is ignored.
- FSM: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1 (combinational: state==IDLE).
  - load_valid=1 in cycle T: the tx register latches load_data, bit counter=0, next state SHIFT.
  - abort in IDLE is ignored.
- SHIFT:
  - shift_en=1 during cycles T+1..T+WIDTH, exactly WIDTH cycles.
  - ser_out = current tx head bit; the tx register shifts one position per cycle.
  - Each cycle, ser_in shifts into the rx register. It enters from the opposite end to the tx shift, so a zero-latency loopback (ser_in = ser_out) reproduces load_data.
  - On the cycle with counter==WIDTH-1: cap_data <= completed rx word and cap_valid=1 in cycle T+WIDTH+1. Next state is GAP, or IDLE when GAP=0.
  - load_valid is ignored (load_ready=0).
- abort in SHIFT:
  - shift_en drops in the next cycle, aborted pulses in the next cycle, and cap_data is not updated.
  - Next state is GAP (or IDLE when GAP=0).
  - abort on the final shift cycle wins: no cap_valid.
- GAP:
  - Runs GAP cycles, with shift_en=0, ser_out=0 and load_ready=0. abort is ignored.
  - Then IDLE. The earliest next accept is cycle T+WIDTH+GAP+1.
- Outside SHIFT: ser_out is held at 0.
- cap_valid and aborted are never both 1.
- There is no backpressure on cap_valid. The consumer must take cap_data within WIDTH+GAP+1 cycles; cap_data holds its value until the next completed frame.
- Bit counter width: clog2(WIDTH). It resets to 0 on every accept and every abort.
- Reset mid-SHIFT: immediate return to the reset values on the next edge, with no cap_valid and no aborted pulse.

Decomposition:
- Package shift_ctrl_pkg holds:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2)
  - a clog2 constant function for the counter widths
- One sub-module, shift_word_reg, instantiated twice (tx and rx). Parameters WIDTH and LSB_FIRST; ports clk, rst, load, load_data, shift, sin, sout, q.

Test Plan:
- Reset: assert rst for 2 cycles with load_valid=1 -> all outputs at reset values, no accept; load_ready=1 the cycle after rst falls.
- Loopback, WIDTH=10, GAP=2, MSB first, ser_in=ser_out, load 10'h2B5 at T -> shift_en high T+1..T+10; ser_out sequence 1,0,1,0,1,1,0,1,0,1; cap_valid at T+11 with cap_data=10'h2B5; load_ready=1 again at T+13.
- LSB_FIRST=1, load 10'h001, ser_in tied 1 -> first ser_out bit is 1, rest are 0; cap_data=10'h3FF.
- Back-to-back: load_valid held high with two words -> second accept exactly at T+WIDTH+GAP+1; two cap_valid pulses 13 cycles apart.
- Abort at the 4th shift cycle -> shift_en low next cycle, aborted pulse, no cap_valid, cap_data unchanged, load_ready after GAP.
- GAP=0, abort in the same cycle as a load accept in IDLE -> load accepted and the full frame completes with cap_valid.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-chain sequencer.
// Contents: the state encoding for the sequencer FSM and a ceil-log2
// helper that sizes the frame and gap counters.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns ceil(log2(n)). The result is never below 1, so a counter
  // sized with it always has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_word_reg.sv
// Parallel-load shift register. It is used once for the transmit word
// and once for the receive word.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (q clears to 0)
//   load      : capture load_data; takes priority over shift
//   load_data : parallel word
//   shift     : shift one position and take sin into the vacated end
//   sin       : serial input
//   sout      : bit that leaves next (q[0] if LSB_FIRST, else q[WIDTH-1])
//   q         : register contents
module shift_word_reg
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= (LSB_FIRST != 0) ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
    end
  end

  assign sout = (LSB_FIRST != 0) ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a serial shift chain. It accepts a parallel word over a
// valid/ready handshake and shifts it out over WIDTH cycles. During the
// same cycles it assembles the word returned from the chain tail. Each
// frame is followed by a GAP-cycle idle gap.
// Ports:
//   clk, rst                          : clock and synchronous active-high reset
//   load_valid, load_data, load_ready : word handshake (accepted when IDLE)
//   abort                             : terminate a frame in progress
//   ser_in                            : chain tail, sampled while shift_en=1
//   shift_en, ser_out                 : chain enable and head bit
//   busy                              : not IDLE
//   cap_valid, cap_data               : pulse and word for each completed frame
//   aborted                           : pulse for each aborted frame
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for load_valid; load_ready=1
// ST_SHIFT | shift_en=1, one bit out and one bit in per cycle
// ST_GAP   | forced idle gap of GAP cycles after a frame ends or aborts
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int GAP       = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             ser_out,
  output logic             busy,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output logic             aborted
);

  localparam int CW = clog2_min1(WIDTH);
  localparam int GW = clog2_min1((GAP > 1) ? GAP : 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             shifting, accept, do_abort, last_shift;
  logic             tx_sout;
  logic             rx_sout_unused;
  logic [WIDTH-1:0] tx_q_unused;
  logic [WIDTH-1:0] rx_q, rx_done;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign shifting   = (state == ST_SHIFT);
  assign shift_en   = shifting;
  assign ser_out    = shifting & tx_sout;
  assign accept     = load_ready & load_valid;
  assign do_abort   = shifting & abort;
  // An abort on the final shift cycle suppresses the capture.
  assign last_shift = shifting & (bit_cnt == LAST_BIT) & ~abort;

  // rx word including this cycle's ser_in. On the last shift cycle this
  // is the finished word, one cycle before rx_q itself would hold it.
  assign rx_done = (LSB_FIRST != 0) ? {ser_in, rx_q[WIDTH-1:1]}
                                    : {rx_q[WIDTH-2:0], ser_in};

  shift_word_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (load_data),
    .shift     (shifting),
    .sin       (1'b0),
    .sout      (tx_sout),
    .q         (tx_q_unused)
  );

  shift_word_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data ('0),
    .shift     (shifting),
    .sin       (ser_in),
    .sout      (rx_sout_unused),
    .q         (rx_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (abort || (bit_cnt == LAST_BIT))
                  state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cap_valid <= 1'b0;
      aborted   <= 1'b0;
      cap_data  <= '0;
    end else begin
      state     <= state_nxt;
      cap_valid <= last_shift;
      aborted   <= do_abort;
      if (accept || do_abort) begin
        bit_cnt <= '0;
      end else if (shifting) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      // Preloaded outside GAP so that the gap lasts exactly GAP cycles.
      if (state != ST_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (last_shift) begin
        cap_data <= rx_done;
      end
    end
  end

endmodule
